// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one-hot combinational grant, registered broadcast one cycle later.
// Optional consumer back-pressure port enabled by defining CDB_BACKPRESSURE_EN.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef CDB_BACKPRESSURE_EN
  input  logic                      cdb_stall,
`endif
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [IDX_W-1:0]          cdb_src
);

  // Handshake: req[i] is a valid, grant[i] is its ready; the transfer happens on the
  // rising edge where both are high, and the requester drops req on that same edge.

  logic [IDX_W-1:0]  r_ptr;
  logic              w_stall;
  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [TAG_W-1:0]  w_win_tag;
  logic [DATA_W-1:0] w_win_data;
  logic              w_fire;

`ifdef CDB_BACKPRESSURE_EN
  assign w_stall = cdb_stall;
`else
  assign w_stall = 1'b0;
`endif

  // Search ascending from r_ptr with wrap; the first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    w_win_tag  = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_win_tag  = req_tag[i*TAG_W +: TAG_W];
        w_win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_fire = w_found && rst_n && !w_stall;

  always_comb begin
    grant = '0;
    if (w_fire) grant[w_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (w_fire) begin
      r_ptr     <= (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      cdb_valid <= 1'b1;
      cdb_tag   <= w_win_tag;
      cdb_data  <= w_win_data;
      cdb_src   <= w_win;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single request, round-robin, skip, async reset,
// repeat grants and (with CDB_BACKPRESSURE_EN) stall.
module tb_cdb_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst_n;
  logic                      cdb_stall;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [1:0]                cdb_src;

  int errors = 0;
  int checks = 0;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CDB_BACKPRESSURE_EN
    .cdb_stall (cdb_stall),
`endif
    .req       (req),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .grant     (grant),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_payload(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req   = 4'b1111;
    rst_n = 1'b0;
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", cdb_valid); end
    checks++; if (cdb_tag !== 6'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", cdb_tag); end
    checks++; if (cdb_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", cdb_data); end
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", cdb_src); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    req   = '0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    set_payload(0, 6'd5, 32'hDEADBEEF);
    req = 4'b0001;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
    step();
    req = 4'b0000;
    #1;
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", cdb_valid); end
    checks++; if (cdb_tag !== 6'd5) begin errors++; $display("FAIL single_tag: got %0d want 5", cdb_tag); end
    checks++; if (cdb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", cdb_data); end
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL single_src: got %0d want 0", cdb_src); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_nogrant: got %b want 0000", grant); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %0b want 0", cdb_valid); end
    checks++; if (cdb_tag !== 6'd5) begin errors++; $display("FAIL single_hold_tag: got %0d want 5", cdb_tag); end
    checks++; if (cdb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold_data: got %h want deadbeef", cdb_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [1:0] exp_s [5];
    logic [5:0] exp_t [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_t = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd10};
    do_reset();
    set_payload(0, 6'd10, 32'hA000_0000);
    set_payload(1, 6'd11, 32'hA000_0001);
    set_payload(2, 6'd12, 32'hA000_0002);
    set_payload(3, 6'd13, 32'hA000_0003);
    req = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, exp_g[k]); end
      step();
      checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %0b want 1", k, cdb_valid); end
      checks++; if (cdb_src !== exp_s[k]) begin errors++; $display("FAIL rr_src[%0d]: got %0d want %0d", k, cdb_src, exp_s[k]); end
      checks++; if (cdb_tag !== exp_t[k]) begin errors++; $display("FAIL rr_tag[%0d]: got %0d want %0d", k, cdb_tag, exp_t[k]); end
    end
    checks++; if (cdb_data !== 32'hA000_0000) begin errors++; $display("FAIL rr_data: got %h want a0000000", cdb_data); end
    req = 4'b0000;
    step();
  endtask

  // Starts with ptr=1 left by the round-robin wrap.
  task automatic test_skip();
    req = 4'b1001;
    #1;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL skip_grant3: got %b want 1000", grant); end
    step();
    req = 4'b0001;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL skip_grant0: got %b want 0001", grant); end
    checks++; if (cdb_src !== 2'd3) begin errors++; $display("FAIL skip_src3: got %0d want 3", cdb_src); end
    step();
    req = 4'b0011;
    #1;
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL skip_src0: got %0d want 0", cdb_src); end
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL skip_ptr1: got %b want 0010", grant); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_payload(1, 6'd33, 32'h1234_5678);
    req = 4'b1111;
    step();
    step();
    checks++; if ({cdb_valid, cdb_src} !== 3'b1_01) begin errors++; $display("FAIL arst_pre: got valid=%0b src=%0d want valid=1 src=1", cdb_valid, cdb_src); end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL arst_pre_grant: got %b want 0100", grant); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b want 0", cdb_valid); end
    checks++; if (cdb_tag !== 6'd0) begin errors++; $display("FAIL arst_tag: got %0d want 0", cdb_tag); end
    checks++; if (cdb_data !== 32'd0) begin errors++; $display("FAIL arst_data: got %h want 0", cdb_data); end
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL arst_src: got %0d want 0", cdb_src); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL arst_grant: got %b want 0000", grant); end
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL arst_first_grant: got %b want 0001", grant); end
    step();
    checks++; if ({cdb_valid, cdb_src} !== 3'b1_00) begin errors++; $display("FAIL arst_post: got valid=%0b src=%0d want valid=1 src=0", cdb_valid, cdb_src); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_payload(2, 6'd42, 32'hCAFE_F00D);
    req = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want 0100", k, grant); end
      step();
      checks++; if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'd2, 6'd42}) begin
        errors++; $display("FAIL b2b_bus[%0d]: got valid=%0b src=%0d tag=%0d want 1/2/42", k, cdb_valid, cdb_src, cdb_tag);
      end
    end
    // ptr wrapped to 3 past FU2; FU3 now beats FU2.
    req = 4'b1100;
    #1;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL b2b_wrap: got %b want 1000", grant); end
    req = 4'b0000;
    step();
  endtask

`ifdef CDB_BACKPRESSURE_EN
  task automatic test_stall();
    do_reset();
    set_payload(0, 6'd7, 32'h0BAD_F00D);
    req       = 4'b0011;
    cdb_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_grant[%0d]: got %b want 0000", k, grant); end
      step();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %0b want 0", k, cdb_valid); end
    end
    cdb_stall = 1'b0;
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL stall_release_grant: got %b want 0001", grant); end
    step();
    checks++; if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'd0, 6'd7}) begin
      errors++; $display("FAIL stall_bcast: got valid=%0b src=%0d tag=%0d want 1/0/7", cdb_valid, cdb_src, cdb_tag);
    end
    req = 4'b0000;
    step();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    cdb_stall = 1'b0;
    req       = '0;
    req_tag   = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_async_reset();
    test_back_to_back();
`ifdef CDB_BACKPRESSURE_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Responder end of the common data bus (CDB) request/grant handshake used by the ALU and other functional units.
- Each cycle it accepts zero or more CDB requests, each with a stable tag/data.
- It grants exactly one requester using round-robin priority.
- It broadcasts the winner's tag and data on a registered CDB one cycle later, to the ROB, issue queues and register file.

Parameters:
- NUM_REQ, 4, number of requesting functional units (index 0 = ALU1, 1 = ALU2, 2/3 = other FUs).
- TAG_W, 6, width of the physical-register tag.
- DATA_W, 32, width of the result data.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  per-FU CDB request; held high until granted.
- req_tag  input  NUM_REQ*TAG_W  flattened tags; slice i = req_tag[i*TAG_W +: TAG_W].
- req_data  input  NUM_REQ*DATA_W  flattened results; slice i = req_data[i*DATA_W +: DATA_W].
- grant  output  NUM_REQ  one-hot combinational grant, same cycle as req.
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_W  registered broadcast tag.
- cdb_data  output  DATA_W  registered broadcast data.
- cdb_src  output  $clog2(NUM_REQ)  index of the FU whose result is on the bus.
- cdb_stall  input  1  consumer back-pressure; present only with CDB_BACKPRESSURE_EN.

Behaviour:
- Reset (async, rst_n low):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - Priority pointer ptr=0.
  - grant=0 while rst_n low.
- Grant logic (combinational):
  - Search req starting at index ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - The first set bit wins; grant is one-hot on that bit, otherwise all zero.
  - grant[i] is never 1 when req[i]=0.
- Handshake:
  - The requester observes grant[i]=1 at the rising edge and drops req on that same edge.
  - The arbiter must not rely on req falling. A requester that re-asserts req the next cycle is a new transaction.
- Broadcast stage (registered, latency 1 cycle from grant):
  - On an edge with a grant: cdb_valid<=1, cdb_tag<=winner tag, cdb_data<=winner data, cdb_src<=winner index.
  - On an edge without a grant: cdb_valid<=0; cdb_tag, cdb_data and cdb_src hold their previous values.
- Pointer update:
  - On an edge with a grant to index w: ptr <= (w+1) mod NUM_REQ.
  - No grant: ptr holds.
- Fairness: a continuously requesting FU is granted within NUM_REQ cycles, whatever other FUs do.
- Throughput: one grant per cycle maximum; back-to-back grants to different FUs on consecutive cycles are allowed.
- Single requester: the same FU may be granted on consecutive cycles if it re-requests; ptr wraps past it each time.
- Reset mid-operation: pending requests are dropped from arbiter state; ptr returns to 0; any in-flight broadcast is cleared (cdb_valid=0).
- No internal buffering: a request not granted stays with the FU.

Optional Feature:
- Macro: CDB_BACKPRESSURE_EN.
- Defined:
  - The cdb_stall port exists.
  - While cdb_stall=1, grant=0 and ptr holds; cdb_valid<=0 on the next edge; tag/data/src hold.
  - Requests simply wait.
- Undefined:
  - No cdb_stall port; behaviour as if cdb_stall is tied to 0.

Test Plan:
- Reset -> cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, grant=0, ptr=0.
- Single request: req=4'b0001, tag0=6'd5, data0=32'hDEADBEEF.
  - grant=4'b0001 in the same cycle.
  - Next cycle: cdb_valid=1, cdb_tag=5, cdb_data=DEADBEEF, cdb_src=0.
  - Following cycle with req=0: cdb_valid=0, tag/data hold.
- Round-robin: req=4'b1111 held constant for 5 cycles -> grants 0001, 0010, 0100, 1000, 0001 (wrap); cdb_src sequence 0, 1, 2, 3, 0, each one cycle after its grant.
- Fairness / skip: ptr=1, req=4'b1001 -> grant=1000; next cycle req=4'b0001 -> grant=0001, ptr=1.
- Async reset mid-stream: assert rst_n low while cdb_valid=1 and ptr=2 -> outputs clear immediately, no clock needed; after release with req=4'b1111, first grant=0001.
- CDB_BACKPRESSURE_EN defined: req=4'b0011, cdb_stall=1 for 2 cycles -> grant=0, cdb_valid=0. Then cdb_stall=0 -> grant=0001 and broadcast one cycle later.
